// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM port arbiter: requester ids and the
// read-return tag that travels alongside the BRAM read latency.
package bram_arb_pkg;

   localparam int NUM_REQ      = 2;
   localparam int READ_LAT_DEF = 2;

   typedef logic [0:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// READ_LAT-deep shift register of read tags; the output stage lines up with
// the cycle in which the BRAM presents the data for the tagged read.
module bram_rd_tag_pipe
   import bram_arb_pkg::*;
#(
   parameter int READ_LAT = READ_LAT_DEF
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage [READ_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[READ_LAT-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for the audio clip BRAM port: one access per cycle,
// registered BRAM drive, tagged read return. Macro BRAM_ARB_FIXED_PRIO_EN
// makes requester 0 win every tie instead of round robin.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int READ_LAT = READ_LAT_DEF,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [3:0]        we0,
   input  logic [3:0]        we1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [31:0]       BRAM_addr,
   output logic              BRAM_clk,
   output logic [DATA_W-1:0] BRAM_din,
   input  logic [DATA_W-1:0] BRAM_dout,
   output logic              BRAM_en,
   output logic              BRAM_rst,
   output logic [3:0]        BRAM_we
);

   logic              any_gnt;
   req_id_t           sel_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        sel_we;
   logic [DATA_W-1:0] sel_wdata;
   rd_tag_t           tag_in;
   rd_tag_t           tag_out;

`ifndef BRAM_ARB_FIXED_PRIO_EN
   req_id_t last_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          last_grant <= 1'b1;
      else if (any_gnt) last_grant <= sel_id;
   end
`endif

   // Grants are suppressed while rst is high so nothing enters the tag pipe.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (req0 && req1) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            if (last_grant == 1'b1) gnt0 = 1'b1;
            else                    gnt1 = 1'b1;
`endif
         end else if (req0) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign any_gnt   = gnt0 | gnt1;
   assign sel_id    = req_id_t'(gnt1);
   assign sel_addr  = gnt1 ? addr1  : addr0;
   assign sel_we    = gnt1 ? we1    : we0;
   assign sel_wdata = gnt1 ? wdata1 : wdata0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         BRAM_addr <= '0;
         BRAM_din  <= '0;
         BRAM_en   <= 1'b0;
         BRAM_we   <= 4'b0000;
         BRAM_rst  <= 1'b1;
      end else begin
         BRAM_rst <= 1'b0;
         if (any_gnt) begin
            BRAM_en   <= 1'b1;
            BRAM_addr <= 32'(sel_addr);
            BRAM_we   <= sel_we;
            BRAM_din  <= sel_wdata;
         end else begin
            BRAM_en <= 1'b0;
            BRAM_we <= 4'b0000;
         end
      end
   end

   assign tag_in = {any_gnt && (sel_we == 4'b0000), sel_id};

   bram_rd_tag_pipe #(
      .READ_LAT (READ_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // BRAM_dout is the BRAM's own output register; it is routed to the owning
   // requester in the cycle its tag reaches the end of the pipe.
   assign rvalid0  = tag_out.valid && (tag_out.id == 1'b0);
   assign rvalid1  = tag_out.valid && (tag_out.id == 1'b1);
   assign rdata0   = rvalid0 ? BRAM_dout : '0;
   assign rdata1   = rvalid1 ? BRAM_dout : '0;
   assign BRAM_clk = clk;

endmodule
